instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Inverse of the main control decoder. Takes field-level instruction requests (kind, registers, funct, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I word for the supported set: LW, SW, R_TYPE, BEQ.
- Writes each word sequentially into instruction memory.
- Used by bench and boot logic to build programs that the fetch/decode path then executes.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 256: number of writable words, 1..2**ADDR_W.
- BASE_ADDR, 0: first word address written after reset or after program completion.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_kind  in  2  0=LW, 1=SW, 2=R_TYPE, 3=BEQ.
- req_funct3  in  3  R_TYPE only; ignored otherwise.
- req_funct7  in  7  R_TYPE only; ignored otherwise.
- req_rd  in  5  destination register (LW, R_TYPE).
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2 (SW, R_TYPE, BEQ).
- req_imm  in  13  signed immediate; byte offset for LW/SW/BEQ.
- req_last  in  1  final instruction of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  sticky error flag.
- count  out  ADDR_W+1  words written in the current program.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - state=IDLE, req_ready=1.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - done=0, err=0, count=0.
  - An in-flight write is abandoned; no memory write occurs in the reset cycle.
- States: IDLE, WRITE, DONE, FULL.
- IDLE:
  - req_ready=1.
  - On req_valid, run the immediate check:
    - pass: encode the request into imem_wdata, capture req_last, go to WRITE;
    - fail: set err, drop the request (no write), stay in IDLE.
  - No request: stay in IDLE.
- WRITE:
  - req_ready=0, imem_we=1 for exactly one cycle.
  - Next cycle: imem_addr+1 and count+1.
  - Transitions: last → DONE; else count reaching DEPTH → FULL; else → IDLE.
  - Latency is accept cycle N → imem_we in cycle N+1. Throughput is 1 word per 2 cycles.
- DONE:
  - done=1 for one cycle, req_ready=0.
  - imem_addr reloads BASE_ADDR, count→0, then IDLE.
- FULL:
  - req_ready=0, err=1, held until rst.
  - Writing into the last slot (DEPTH-th word) with req_last=1 goes to DONE, not FULL.
- Encodings (opcode / funct3):
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
  - R_TYPE: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
- Immediate checks:
  - LW/SW fail if req_imm[12] != req_imm[11] (out of 12-bit signed range).
  - BEQ fails if req_imm[0]=1.
  - R_TYPE ignores req_imm.
- imem_addr wrap: none. FULL occurs before the address could exceed BASE_ADDR+DEPTH-1.
- imem_wdata holds its last value when imem_we=0.

Optional Feature:
- Macro: INSTR_HALT_PAD_EN.
- Defined:
  - After writing a req_last word, enter state HALT.
  - HALT writes 0x00000063 (beq x0,x0,0 self-loop) at the next address, one imem_we cycle, count+1.
  - Then go to DONE.
  - If no slot remains for the pad, go to FULL instead of DONE.
- Undefined: HALT state absent; req_last goes straight to DONE.

Test Plan:
- LW rd=5 rs1=2 imm=8 → imem_we at addr 0, wdata 0x00812283, count=1, req_ready low one cycle.
- SW rs2=6 rs1=3 imm=12, then R_TYPE rd=1 rs1=2 rs2=3 funct3=0 funct7=0x20 with last=1 → wdata 0x0061A623 @0, 0x403100B3 @1; done pulses; imem_addr back to 0.
- BEQ rs1=1 rs2=2 imm=-4 → 0xFE208EE3. BEQ imm=3 → err=1, no imem_we, req_ready stays 1.
- DEPTH=4, five back-to-back LW with req_valid held → 4 writes at addr 0..3, then FULL, req_ready=0, err=1 until rst.
- rst asserted in the WRITE cycle → no write, all outputs at reset values next cycle. With INSTR_HALT_PAD_EN, a single last=1 ADD → 0x003100B3 @0, 0x00000063 @1, then done.

Source files
------------

// File: rtl/instr_encode_loader.sv
// instr_encode_loader
//   Accepts field-level instruction requests (LW, SW, R_TYPE, BEQ) over a
//   valid/ready handshake, encodes each into a 32-bit RV32I word and writes it
//   sequentially into instruction memory starting at BASE_ADDR.
//
// Optional feature macro: INSTR_HALT_PAD_EN
//   When defined, a "beq x0,x0,0" self-loop (0x00000063) is appended after the
//   last instruction of each program, space permitting.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle
//   req_kind      0=LW 1=SW 2=R_TYPE 3=BEQ
//   req_funct3/7  R_TYPE function fields
//   req_rd/rs1/rs2 register fields
//   req_imm       13-bit signed byte offset (LW/SW/BEQ)
//   req_last      final instruction of the program
//   imem_we       instruction-memory write strobe
//   imem_addr     word address
//   imem_wdata    encoded instruction (held while imem_we=0)
//   done          one-cycle pulse after the program is written
//   err           sticky error (bad immediate or memory full)
//   count         words written in the current program
module instr_encode_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       HaltWord = 32'h0000_0063;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StDone,
        StFull
`ifdef INSTR_HALT_PAD_EN
        ,
        StHalt
`endif
    } state_e;

    state_e          state_q;
    logic            last_q;
    logic            we_q;
    logic [31:0]     enc_word;
    logic            imm_ok;
    logic [ADDR_W:0] count_inc;

    assign count_inc = count + 1'b1;

    // Reset must suppress a write that is already in flight this cycle.
    assign imem_we = we_q & ~rst;

    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b1;
        unique case (req_kind)
            2'd0: begin
                enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
                imm_ok   = (req_imm[12] == req_imm[11]);
            end
            2'd1: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0],
                            7'b0100011};
                imm_ok   = (req_imm[12] == req_imm[11]);
            end
            2'd2: begin
                enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            end
            2'd3: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                            req_imm[4:1], req_imm[11], 7'b1100011};
                imm_ok   = ~req_imm[0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            req_ready  <= 1'b1;
            imem_addr  <= BaseAddr;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            we_q <= 1'b0;
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (imm_ok) begin
                            imem_wdata <= enc_word;
                            last_q     <= req_last;
                            we_q       <= 1'b1;
                            req_ready  <= 1'b0;
                            state_q    <= StWrite;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    imem_addr <= imem_addr + 1'b1;
                    count     <= count_inc;
                    if (last_q) begin
`ifdef INSTR_HALT_PAD_EN
                        if (count_inc == DepthCnt) begin
                            // No slot left for the halt pad.
                            err     <= 1'b1;
                            state_q <= StFull;
                        end else begin
                            imem_wdata <= HaltWord;
                            we_q       <= 1'b1;
                            state_q    <= StHalt;
                        end
`else
                        done    <= 1'b1;
                        state_q <= StDone;
`endif
                    end else if (count_inc == DepthCnt) begin
                        err     <= 1'b1;
                        state_q <= StFull;
                    end else begin
                        req_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
`ifdef INSTR_HALT_PAD_EN
                StHalt: begin
                    imem_addr <= imem_addr + 1'b1;
                    count     <= count_inc;
                    done      <= 1'b1;
                    state_q   <= StDone;
                end
`endif
                StDone: begin
                    imem_addr <= BaseAddr;
                    count     <= '0;
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                StFull: begin
                    // Terminal until reset.
                    req_ready <= 1'b0;
                    err       <= 1'b1;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_kind = '0;
    logic [2:0]        req_funct3 = '0;
    logic [6:0]        req_funct7 = '0;
    logic [4:0]        req_rd = '0;
    logic [4:0]        req_rs1 = '0;
    logic [4:0]        req_rs2 = '0;
    logic [12:0]       req_imm = '0;
    logic              req_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    instr_encode_loader #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_funct3(req_funct3),
        .req_funct7(req_funct7),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .req_last  (req_last),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Log every memory write seen at a clock edge.
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    // ---------------- reference model ----------------
    function automatic int sx13(input logic [12:0] imm);
        int iv;
        iv = int'(imm);
        if (imm[12]) iv = iv - 8192;
        return iv;
    endfunction

    function automatic bit legal_model(input logic [1:0] kind, input logic [12:0] imm);
        int iv;
        iv = sx13(imm);
        if (kind == 2'd0 || kind == 2'd1) return (iv >= -2048) && (iv <= 2047);
        if (kind == 2'd3) return (iv % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] enc_model(input logic [1:0] kind, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [12:0] imm);
        bit [31:0] u;
        bit [31:0] r;
        u = 32'(sx13(imm));
        case (kind)
            2'd0: r = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'd2 << 12)
                      | (32'(rd) << 7) | 32'h03;
            2'd1: r = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'd2 << 12) | ((u & 32'h1F) << 7) | 32'h23;
            2'd2: r = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
            default: r = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | (32'(rs1) << 15) | (((u >> 1) & 32'hF) << 8)
                      | (((u >> 11) & 32'h1) << 7) | 32'h63;
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm, input logic last);
        req_kind = kind; req_funct3 = f3; req_funct7 = f7; req_rd = rd;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_last = last;
        req_valid = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else n_pass++;
        n_checks++; if (imem_addr !== 8'd0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_checks++; if (count !== 9'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_lw();
        do_reset();
        set_req(2'd0, 3'd0, 7'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1) $display("FAIL lw_we: got %b want 1", imem_we); else n_pass++;
        n_checks++; if (imem_addr !== 8'd0) $display("FAIL lw_addr: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (imem_wdata !== 32'h00812283) $display("FAIL lw_data: got %h want 00812283", imem_wdata); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL lw_busy: got %b want 0", req_ready); else n_pass++;
        tick();
        n_checks++; if (imem_we !== 1'b0) $display("FAIL lw_we_off: got %b want 0", imem_we); else n_pass++;
        n_checks++; if (count !== 9'd1) $display("FAIL lw_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL lw_ready: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (imem_wdata !== 32'h00812283) $display("FAIL lw_hold: got %h want 00812283", imem_wdata); else n_pass++;
    endtask

    task automatic test_program();
        do_reset();
        set_req(2'd1, 3'd0, 7'd0, 5'd0, 5'd3, 5'd6, 13'd12, 1'b0);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'h0061A623 || imem_addr !== 8'd0 || imem_we !== 1'b1)
            $display("FAIL sw_write: got we=%b addr=%h data=%h want 1/00/0061a623", imem_we, imem_addr, imem_wdata); else n_pass++;
        tick();
        set_req(2'd2, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 13'd0, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'h403100B3 || imem_addr !== 8'd1 || imem_we !== 1'b1)
            $display("FAIL r_write: got we=%b addr=%h data=%h want 1/01/403100b3", imem_we, imem_addr, imem_wdata); else n_pass++;
        tick();
`ifdef INSTR_HALT_PAD_EN
        n_checks++; if (imem_wdata !== 32'h00000063 || imem_addr !== 8'd2 || imem_we !== 1'b1)
            $display("FAIL prog_pad: got we=%b addr=%h data=%h want 1/02/00000063", imem_we, imem_addr, imem_wdata); else n_pass++;
        tick();
`endif
        n_checks++; if (done !== 1'b1) $display("FAIL prog_done: got %b want 1", done); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL prog_done_ready: got %b want 0", req_ready); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL prog_done_pulse: got %b want 0", done); else n_pass++;
        n_checks++; if (imem_addr !== 8'd0 || count !== 9'd0)
            $display("FAIL prog_reload: got addr=%h count=%0d want 0/0", imem_addr, count); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL prog_ready: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_beq();
        do_reset();
        set_req(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b0);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'hFE208EE3) $display("FAIL beq_data: got %h want fe208ee3", imem_wdata); else n_pass++;
        tick();
        wr_addr_q.delete();
        wr_data_q.delete();
        set_req(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
        tick();
        req_valid = 1'b0;
        n_checks++; if (err !== 1'b1) $display("FAIL beq_err: got %b want 1", err); else n_pass++;
        n_checks++; if (imem_we !== 1'b0) $display("FAIL beq_nowe: got %b want 0", imem_we); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL beq_ready: got %b want 1", req_ready); else n_pass++;
        tick();
        n_checks++; if (wr_addr_q.size() != 0) $display("FAIL beq_nowrite: got %0d writes want 0", wr_addr_q.size()); else n_pass++;
        n_checks++; if (err !== 1'b1 || count !== 9'd1) $display("FAIL beq_sticky: got err=%b count=%0d want 1/1", err, count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int nacc;
        do_reset();
        wr_addr_q.delete();
        wr_data_q.delete();
        nacc = 0;
        for (int c = 0; c < 14; c++) begin
            set_req(2'd0, 3'd0, 7'd0, 5'($urandom), 5'($urandom), 5'd0,
                    13'($urandom_range(0, 2047)), 1'b0);
            // Accepts happen every other cycle until DEPTH words are written.
            if (c % 2 == 0 && nacc < DEPTH) begin
                exp_q.push_back(enc_model(req_kind, req_funct3, req_funct7, req_rd, req_rs1,
                                          req_rs2, req_imm));
                nacc++;
            end
            tick();
        end
        n_checks++; if (wr_addr_q.size() != DEPTH) $display("FAIL full_nwrites: got %0d want %0d", wr_addr_q.size(), DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_q[i])
                $display("FAIL full_write%0d: got addr=%h data=%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 8'(i), exp_q[i]); else n_pass++;
        end
        n_checks++; if (req_ready !== 1'b0 || err !== 1'b1)
            $display("FAIL full_state: got ready=%b err=%b want 0/1", req_ready, err); else n_pass++;
        n_checks++; if (count !== 9'(DEPTH)) $display("FAIL full_count: got %0d want %0d", count, DEPTH); else n_pass++;
        req_valid = 1'b0;
        do_reset();
        n_checks++; if (req_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL full_clear: got ready=%b err=%b want 1/0", req_ready, err); else n_pass++;
    endtask

    task automatic test_reset_in_write();
        int n0;
        do_reset();
        set_req(2'd0, 3'd0, 7'd0, 5'd7, 5'd4, 5'd0, 13'd16, 1'b0);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1) $display("FAIL rw_pre_we: got %b want 1", imem_we); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (imem_we !== 1'b0) $display("FAIL rw_we_gated: got %b want 0", imem_we); else n_pass++;
        n0 = wr_addr_q.size();
        tick();
        n_checks++; if (wr_addr_q.size() != n0) $display("FAIL rw_nowrite: got %0d writes want %0d", wr_addr_q.size(), n0); else n_pass++;
        n_checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'd0 || done !== 1'b0
                         || err !== 1'b0 || count !== 9'd0 || req_ready !== 1'b1)
            $display("FAIL rw_outputs: got we=%b addr=%h data=%h done=%b err=%b count=%0d ready=%b want reset values",
                     imem_we, imem_addr, imem_wdata, done, err, count, req_ready); else n_pass++;
        rst = 1'b0;
    endtask

`ifdef INSTR_HALT_PAD_EN
    task automatic test_halt_pad();
        do_reset();
        set_req(2'd2, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'h003100B3 || imem_addr !== 8'd0)
            $display("FAIL halt_add: got addr=%h data=%h want 00/003100b3", imem_addr, imem_wdata); else n_pass++;
        tick();
        n_checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00000063 || imem_addr !== 8'd1)
            $display("FAIL halt_pad: got we=%b addr=%h data=%h want 1/01/00000063", imem_we, imem_addr, imem_wdata); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1 || count !== 9'd2) $display("FAIL halt_done: got done=%b count=%0d want 1/2", done, count); else n_pass++;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [1:0]  kind;
        logic [12:0] imm;
        logic [11:0] v12;
        logic [31:0] exp;
        logic        bad;
        logic        last;
        logic        exp_err;
        int          nlegal;
        int          issued;
        int          exp_addr;
        for (int p = 0; p < 20; p++) begin
            do_reset();
            nlegal   = $urandom_range(1, 3);
            issued   = 0;
            exp_addr = 0;
            exp_err  = 1'b0;
            while (issued < nlegal) begin
                kind = 2'($urandom_range(0, 3));
                bad  = (kind != 2'd2) && ($urandom_range(0, 3) == 0);
                if (kind == 2'd0 || kind == 2'd1) begin
                    v12 = 12'($urandom);
                    imm = {v12[11] ^ bad, v12};
                end else begin
                    imm = 13'($urandom);
                    if (kind == 2'd3) imm[0] = bad;
                end
                last = !bad && (issued == nlegal - 1);
                set_req(kind, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), imm, last);
                exp = enc_model(kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, imm);
                tick();
                req_valid = 1'b0;
                if (!legal_model(kind, imm)) begin
                    exp_err = 1'b1;
                    n_checks++; if (imem_we !== 1'b0 || err !== 1'b1 || req_ready !== 1'b1)
                        $display("FAIL rnd_reject p%0d: got we=%b err=%b ready=%b want 0/1/1", p, imem_we, err, req_ready); else n_pass++;
                end else begin
                    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 8'(exp_addr) || imem_wdata !== exp)
                        $display("FAIL rnd_write p%0d: got we=%b addr=%h data=%h want 1/%h/%h", p, imem_we, imem_addr, imem_wdata, 8'(exp_addr), exp); else n_pass++;
                    tick();
                    exp_addr++;
                    issued++;
                    if (last) begin
`ifdef INSTR_HALT_PAD_EN
                        n_checks++; if (imem_we !== 1'b1 || imem_addr !== 8'(exp_addr) || imem_wdata !== 32'h63)
                            $display("FAIL rnd_pad p%0d: got we=%b addr=%h data=%h want 1/%h/00000063", p, imem_we, imem_addr, imem_wdata, 8'(exp_addr)); else n_pass++;
                        tick();
                        exp_addr++;
`endif
                        n_checks++; if (done !== 1'b1 || count !== 9'(exp_addr) || err !== exp_err)
                            $display("FAIL rnd_done p%0d: got done=%b count=%0d err=%b want 1/%0d/%b", p, done, count, err, exp_addr, exp_err); else n_pass++;
                        tick();
                        n_checks++; if (imem_addr !== 8'd0 || count !== 9'd0 || req_ready !== 1'b1)
                            $display("FAIL rnd_reload p%0d: got addr=%h count=%0d ready=%b want 0/0/1", p, imem_addr, count, req_ready); else n_pass++;
                    end else begin
                        n_checks++; if (req_ready !== 1'b1 || count !== 9'(exp_addr))
                            $display("FAIL rnd_idle p%0d: got ready=%b count=%0d want 1/%0d", p, req_ready, count, exp_addr); else n_pass++;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_program();
        test_beq();
        test_back_to_back();
        test_reset_in_write();
`ifdef INSTR_HALT_PAD_EN
        test_halt_pad();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
